ccff_bitstream_loader: RTL and testbench

Configuration-chain loader that sits directly upstream of the fabric tiles' `ccff_head` input. It accepts configuration bitstream words over a valid/ready stream and serialises them MSB-first onto the configuration flip-flop chain. It emits a chain clock-enable for the external `prog_clk` gate and raises `cfg_done` once exactly `CHAIN_LEN` bits have been shifted. `cfg_done` fans out to every tile's `cfg_done` global port.

---
 rtl/ccff_loader_pkg.sv | 24 ++
 rtl/ccff_crc16.sv | 24 ++
 rtl/ccff_bitstream_loader.sv | 146 ++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC helpers for the configuration-chain loader.
// CHECK/ERR are only reachable when built with CCFF_CRC_EN.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first CRC-16-CCITT step for a single input bit.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16.sv
// Serial CRC-16-CCITT accumulator, one bit per enabled cycle.
// Used by the loader only when built with CCFF_CRC_EN.
module ccff_crc16
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc_q <= CRC_INIT;
    else if (clr) crc_q <= CRC_INIT;
    else if (en)  crc_q <= crc_step(crc_q, din);
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams bitstream words MSB-first onto the ccff chain with a registered clock-enable.
// Build with CCFF_CRC_EN to add a trailing CRC word check (CHECK/ERR states).
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 4096
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ccff_head,
  output logic              ccff_en,
  output logic              busy,
  output logic              cfg_done,
  output logic              error
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(WORD_W + 1);

  state_t            state_q;
  logic [CW-1:0]     bcnt_q;
  logic [WW-1:0]     wcnt_q;
  logic [WORD_W-1:0] sh_q;
  logic              rdy_q, head_q, en_q, busy_q, done_q;
  logic              chain_full, word_empty;
  logic [CW-1:0]     bcnt_inc;

  assign chain_full = (bcnt_q == CW'(CHAIN_LEN));
  assign word_empty = (wcnt_q == WW'(WORD_W));
  assign bcnt_inc   = chain_full ? bcnt_q : bcnt_q + CW'(1);

`ifdef CCFF_CRC_EN
  logic        err_q, crc_clr;
  logic [15:0] crc;

  assign crc_clr = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);

  // CRC samples exactly what the chain captures: head on enabled edges.
  ccff_crc16 u_crc (
    .clk   (prog_clk),
    .rst_n (prog_reset),
    .en    (en_q),
    .clr   (crc_clr),
    .din   (head_q),
    .crc   (crc)
  );
`endif

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      sh_q    <= '0;
      rdy_q   <= 1'b0;
      head_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CCFF_CRC_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE
`ifdef CCFF_CRC_EN
        , ST_ERR
`endif
        : if (start) begin
          state_q <= ST_LOAD;
          bcnt_q  <= '0;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
`ifdef CCFF_CRC_EN
          err_q   <= 1'b0;
`endif
        end
        // The handshake edge already presents bit 0, so SHIFT only counts the rest.
        ST_LOAD: if (s_valid) begin
          state_q <= ST_SHIFT;
          rdy_q   <= 1'b0;
          head_q  <= s_data[WORD_W-1];
          sh_q    <= s_data << 1;
          en_q    <= 1'b1;
          wcnt_q  <= WW'(1);
          bcnt_q  <= bcnt_inc;
        end
        ST_SHIFT: begin
          if (chain_full) begin
            en_q    <= 1'b0;
`ifdef CCFF_CRC_EN
            state_q <= ST_CHECK;
            rdy_q   <= 1'b1;
`else
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else if (word_empty) begin
            state_q <= ST_LOAD;
            en_q    <= 1'b0;
            rdy_q   <= 1'b1;
          end else begin
            head_q  <= sh_q[WORD_W-1];
            sh_q    <= sh_q << 1;
            en_q    <= 1'b1;
            wcnt_q  <= wcnt_q + WW'(1);
            bcnt_q  <= bcnt_inc;
          end
        end
`ifdef CCFF_CRC_EN
        ST_CHECK: if (s_valid) begin
          rdy_q  <= 1'b0;
          busy_q <= 1'b0;
          if (s_data[15:0] == crc) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ERR;
            err_q   <= 1'b1;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready   = rdy_q;
  assign ccff_head = head_q;
  assign ccff_en   = en_q;
  assign busy      = busy_q;
  assign cfg_done  = done_q;
`ifdef CCFF_CRC_EN
  assign error     = err_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: expected chain bits queued at each data handshake, popped on every ccff_en cycle.
// Build with CCFF_CRC_EN to also exercise the CRC word check.
module tb_ccff_bitstream_loader;

  localparam int W  = 32;
  localparam int CL = 40;

  logic        prog_clk = 1'b0;
  logic        prog_reset = 1'b1;
  logic        start = 1'b0, s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, ccff_head, ccff_en, busy, cfg_done, error;

  logic        start2 = 1'b0, s_valid2 = 1'b0;
  logic [31:0] s_data2 = '0;
  logic        s_ready2, head2, en2, busy2, done2, err2;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(CL)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ccff_head(ccff_head), .ccff_en(ccff_en), .busy(busy),
    .cfg_done(cfg_done), .error(error));

  ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(32)) dut32 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start2),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
    .ccff_head(head2), .ccff_en(en2), .busy(busy2),
    .cfg_done(done2), .error(err2));

  int          errors = 0, checks = 0;
  bit          sb[$];
  bit          sb2[$];
  int          en_cnt = 0;
  bit          chk_done_nxt = 0;
  int          pcnt = 0;
  logic [15:0] crc_m = 16'hFFFF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
  endfunction

  // Chain-side monitor for the 40-bit instance.
  always @(negedge prog_clk) begin
    if (!prog_reset) begin
      en_cnt       = 0;
      chk_done_nxt = 0;
    end else begin
      if (start && !busy) en_cnt = 0;
`ifndef CCFF_CRC_EN
      if (chk_done_nxt) begin
        chk("done_edge", {31'd0, cfg_done}, 32'd1);
        chk_done_nxt = 0;
      end
`endif
      if (ccff_en) begin
        en_cnt++;
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("bit", {31'd0, ccff_head}, {31'd0, sb.pop_front()});
        if (en_cnt == CL) chk_done_nxt = 1;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 100) begin
      @(posedge prog_clk); #1;
      n++;
    end
    if (!s_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit crcw);
    int e0;
    wait_ready();
    e0 = en_cnt;
    repeat (gap) begin
      @(posedge prog_clk); #1;
      chk("gap_en_low", {31'd0, ccff_en}, 32'd0);
    end
    if (gap > 0) chk("gap_en_cnt", en_cnt, e0);
    s_valid = 1'b1;
    s_data  = w;
    if (!crcw)
      for (int i = 31; i >= 0; i--)
        if (pcnt < CL) begin
          sb.push_back(w[i]);
          crc_m = crc_bit(crc_m, w[i]);
          pcnt++;
        end
    @(posedge prog_clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic do_start();
    pcnt  = 0;
    crc_m = 16'hFFFF;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    chk("start_rdy", {31'd0, s_ready}, 32'd1);
    chk("start_done_clr", {31'd0, cfg_done}, 32'd0);
    chk("start_err_clr", {31'd0, error}, 32'd0);
  endtask

  task automatic finish_load(input bit bad);
`ifdef CCFF_CRC_EN
    send_word({16'h0000, crc_m ^ {15'd0, bad}}, 0, 1'b1);
    chk("crc_done", {31'd0, cfg_done}, {31'd0, !bad});
    chk("crc_err", {31'd0, error}, {31'd0, bad});
`else
    int n = 0;
    while (!cfg_done && n < 100) begin
      @(posedge prog_clk); #1;
      n++;
    end
    chk("done", {31'd0, cfg_done}, {31'd0, !bad});
    chk("err_tied", {31'd0, error}, 32'd0);
`endif
    chk("en_total", en_cnt, CL);
    chk("sb_empty", sb.size(), 32'd0);
    chk("busy_off", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 prog_reset = 1'b0;
    #1;
    chk("rst_outs", {26'd0, s_ready, ccff_head, ccff_en, busy, cfg_done, error}, 32'd0);
    repeat (3) @(posedge prog_clk);
    #1 prog_reset = 1'b1;

    // Basic load
    do_start();
    send_word(32'hA5A5A5A5, 0, 1'b0);
    send_word(32'hF0000000, 0, 1'b0);
    finish_load(1'b0);

    // Back-pressure between words
    do_start();
    send_word(32'hA5A5A5A5, 0, 1'b0);
    send_word(32'hF0000000, 5, 1'b0);
    finish_load(1'b0);

    // start mid-SHIFT must be ignored
    do_start();
    send_word(32'hA5A5A5A5, 0, 1'b0);
    repeat (5) @(posedge prog_clk);
    #1 start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    chk("ign_start_busy", {31'd0, busy}, 32'd1);
    send_word(32'hF0000000, 0, 1'b0);
    finish_load(1'b0);

    // start in DONE, then reset during bit 17
    do_start();
    send_word(32'hA5A5A5A5, 0, 1'b0);
    repeat (16) @(posedge prog_clk);
    #2 prog_reset = 1'b0;
    #1;
    chk("rst_mid_outs", {26'd0, s_ready, ccff_head, ccff_en, busy, cfg_done, error}, 32'd0);
    sb.delete();
    repeat (2) @(posedge prog_clk);
    #1 prog_reset = 1'b1;
    repeat (3) begin
      @(posedge prog_clk); #1;
      chk("idle_rdy", {31'd0, s_ready}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
    do_start();
    send_word(32'hA5A5A5A5, 0, 1'b0);
    send_word(32'hF0000000, 0, 1'b0);
    finish_load(1'b0);

`ifdef CCFF_CRC_EN
    // Corrupted CRC word, then recovery via start
    do_start();
    send_word(32'hA5A5A5A5, 0, 1'b0);
    send_word(32'hF0000000, 0, 1'b0);
    finish_load(1'b1);
    do_start();
    send_word(32'h12345678, 0, 1'b0);
    send_word(32'h9ABCDEF0, 0, 1'b0);
    finish_load(1'b0);
`endif

    // Exact-fit single word on the 32-bit chain
    start2 = 1'b1;
    @(posedge prog_clk); #1;
    start2 = 1'b0;
    chk("x_start_rdy", {31'd0, s_ready2}, 32'd1);
    s_valid2 = 1'b1;
    s_data2  = 32'h80000001;
    for (int i = 31; i >= 0; i--) sb2.push_back(s_data2[i]);
    @(posedge prog_clk); #1;
    s_valid2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("x_en", {31'd0, en2}, 32'd1);
      chk("x_bit", {31'd0, head2}, {31'd0, sb2.pop_front()});
      @(posedge prog_clk); #1;
    end
    chk("x_en_off", {31'd0, en2}, 32'd0);
`ifdef CCFF_CRC_EN
    chk("x_check_rdy", {31'd0, s_ready2}, 32'd1);
`else
    chk("x_done", {31'd0, done2}, 32'd1);
    repeat (3) begin
      chk("x_no_req", {31'd0, s_ready2}, 32'd0);
      @(posedge prog_clk); #1;
    end
`endif
    chk("x_err", {31'd0, err2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
